pulse_stretcher: RTL and testbench

//  Converts single-cycle event pulses (e.g. rising-edge detector strobes from
//  the button inputs) back into level outputs.

---
 rtl/pulse_stretcher.sv | 126 ++++++++++++
 tb/tb_pulse_stretcher.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event strobes into level bursts. Each accepted event
//   gives HIGH_CYCLES cycles of out=1, then at least GAP_CYCLES cycles of
//   out=0. Events that arrive during a burst or a gap are counted in a
//   saturating pending counter and replayed in order.
//
// Ports
//   clk       in   1       system clock, posedge
//   rst       in   1       asynchronous reset, active low
//   in        in   1       event strobe, one event per cycle sampled high
//   out       out  1       stretched level, registered
//   busy      out  1       high whenever a burst or gap is in progress
//   pending   out  PEND_W  queued events not yet started
//   overflow  out  1       one-cycle pulse when an event was dropped
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TMAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [PEND_W-1:0] r_pend;
    logic              r_out;
    logic              r_busy;
    logic              r_ovf;

    logic w_tmo;
    logic w_gap_exp;
    logic w_pend_nz;
    logic w_full;
    logic w_direct;
    logic w_inc;
    logic w_dec;

    assign w_tmo     = (r_timer == '0);
    assign w_gap_exp = (r_state == S_GAP) && w_tmo;
    assign w_pend_nz = (r_pend != '0);
    assign w_full    = &r_pend;
    // The queue has priority at gap expiry; the live strobe only starts a
    // burst directly when nothing is waiting ahead of it.
    assign w_dec     = w_gap_exp && w_pend_nz;
    assign w_direct  = in && ((r_state == S_IDLE) || (w_gap_exp && !w_pend_nz));
    assign w_inc     = in && !w_direct;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_pend  <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // Queue bookkeeping. A simultaneous inc and dec leaves the count
            // unchanged, so a full queue only drops when nothing is leaving.
            r_ovf <= 1'b0;
            if (w_inc && !w_dec && w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_pend <= r_pend + PEND_W'(w_inc) - PEND_W'(w_dec);
            end

            case (r_state)
                S_IDLE: begin
                    if (in) begin
                        r_state <= S_HIGH;
                        r_timer <= TW'(HIGH_CYCLES - 1);
                        r_out   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_tmo) begin
                        r_state <= S_GAP;
                        r_timer <= TW'(GAP_CYCLES - 1);
                        r_out   <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (!w_tmo) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_pend_nz || in) begin
                        r_state <= S_HIGH;
                        r_timer <= TW'(HIGH_CYCLES - 1);
                        r_out   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign busy     = r_busy;
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: instance A uses H=4, G=2, PEND_W=2; instance B
// uses H=1, G=1, PEND_W=2. A reference model tracks each instance as "edge
// index of the last burst start" plus a queued-event count.
module tb_pulse_stretcher;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int H2 = 1;
    localparam int G2 = 1;
    localparam int PW = 2;
    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_a = 1'b0;
    logic in_b = 1'b0;
    logic out_a, busy_a, ovf_a;
    logic out_b, busy_b, ovf_b;
    logic [PW-1:0] pend_a, pend_b;

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut_a (
        .clk(clk), .rst(rst), .in(in_a),
        .out(out_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_stretcher #(.HIGH_CYCLES(H2), .GAP_CYCLES(G2), .PEND_W(PW)) dut_b (
        .clk(clk), .rst(rst), .in(in_b),
        .out(out_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    int errs = 0;
    int checks = 0;

    // model state per instance
    int   ta = 0, sa = -1000, pa = 0;
    int   tb = 0, sb = -1000, pb = 0;
    logic oa = 1'b0, ob = 1'b0;

    logic [4:0] obs_a, obs_b;
    assign obs_a = {out_a, busy_a, pend_a, ovf_a};
    assign obs_b = {out_b, busy_b, pend_b, ovf_b};

    // One clock edge of the behavioural model. A new burst may begin once
    // h+g edges have passed since the previous start; a queued event goes
    // first, otherwise the live strobe.
    task automatic model_edge(input int h, input int g, input int pmax, input logic v,
                              inout int t, inout int start, inout int pend, output logic ovf);
        t++;
        ovf = 1'b0;
        if (t - start >= h + g) begin
            if (pend > 0) begin
                start = t;
                pend--;
                if (v) pend++;
            end else if (v) begin
                start = t;
            end
        end else if (v) begin
            if (pend == pmax) ovf = 1'b1;
            else pend++;
        end
    endtask

    function automatic logic [4:0] mexp(input int h, input int g, input int t,
                                        input int start, input int pend, input logic ovf);
        logic o, b;
        o = (t - start) < h;
        b = (t - start) < (h + g);
        return {o, b, 2'(pend), ovf};
    endfunction

    task automatic model_reset();
        sa = -1000; pa = 0; oa = 1'b0;
        sb = -1000; pb = 0; ob = 1'b0;
    endtask

    task automatic step(input logic va, input logic vb);
        in_a = va;
        in_b = vb;
        @(posedge clk);
        model_edge(H, G, PMAX, va, ta, sa, pa, oa);
        model_edge(H2, G2, PMAX, vb, tb, sb, pb, ob);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_a !== 5'b0) begin
            errs++; $display("FAIL reset_a: got %b want %b", obs_a, 5'b0);
        end
        checks++;
        if (obs_b !== 5'b0) begin
            errs++; $display("FAIL reset_b: got %b want %b", obs_b, 5'b0);
        end
        model_reset();
        rst = 1'b1;
        // first event accepted on the first edge after release
        step(1'b1, 1'b0);
        checks++;
        if (out_a !== 1'b1 || busy_a !== 1'b1) begin
            errs++; $display("FAIL reset_release: got out=%b busy=%b want 1 1", out_a, busy_a);
        end
        drain(8);
    endtask

    task automatic test_single();
        logic [4:0] e;
        for (int k = 0; k < 9; k++) begin
            step(k == 0, 1'b0);
            e = {k < 4, k < 6, 2'b00, 1'b0};
            checks++;
            if (obs_a !== e) begin
                errs++; $display("FAIL single k=%0d: got %b want %b", k, obs_a, e);
            end
            checks++;
            if (obs_a !== mexp(H, G, ta, sa, pa, oa)) begin
                errs++; $display("FAIL single_model k=%0d: got %b want %b", k, obs_a, mexp(H, G, ta, sa, pa, oa));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        for (int k = 0; k < 14; k++) begin
            step(k < 2, 1'b0);
            e = {(k < 4) || (k >= 6 && k < 10), k < 12, 2'((k >= 1 && k < 6) ? 1 : 0), 1'b0};
            checks++;
            if (obs_a !== e) begin
                errs++; $display("FAIL back_to_back k=%0d: got %b want %b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_overflow();
        int bursts;
        logic prev;
        bursts = 0;
        prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(k < 5, 1'b0);
            if (out_a && !prev) bursts++;
            prev = out_a;
            checks++;
            if (ovf_a !== (k == 4)) begin
                errs++; $display("FAIL overflow k=%0d: got %b want %b", k, ovf_a, k == 4);
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (pend_a !== 2'((k < 3) ? k : 3)) begin
                    errs++; $display("FAIL overflow_pend k=%0d: got %0d want %0d", k, pend_a, (k < 3) ? k : 3);
                end
            end
            checks++;
            if (obs_a !== mexp(H, G, ta, sa, pa, oa)) begin
                errs++; $display("FAIL overflow_model k=%0d: got %b want %b", k, obs_a, mexp(H, G, ta, sa, pa, oa));
            end
        end
        checks++;
        if (bursts != 4) begin
            errs++; $display("FAIL overflow_bursts: got %0d want 4", bursts);
        end
    endtask

    task automatic test_gap_expiry();
        for (int k = 0; k < 7; k++) step(k < 2 || k == 6, 1'b0);
        checks++;
        if (out_a !== 1'b1 || pend_a !== 2'd1) begin
            errs++; $display("FAIL gap_expiry: got out=%b pend=%0d want out=1 pend=1", out_a, pend_a);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_a !== mexp(H, G, ta, sa, pa, oa)) begin
                errs++; $display("FAIL gap_expiry_model k=%0d: got %b want %b", k, obs_a, mexp(H, G, ta, sa, pa, oa));
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (out_a !== 1'b1 || pend_a !== 2'd2) begin
            errs++; $display("FAIL async_setup: got out=%b pend=%0d want out=1 pend=2", out_a, pend_a);
        end
        in_a = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_a !== 5'b0) begin
            errs++; $display("FAIL async_reset: got %b want %b", obs_a, 5'b0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_a !== 5'b0) begin
                errs++; $display("FAIL async_idle k=%0d: got %b want %b", k, obs_a, 5'b0);
            end
        end
        step(1'b1, 1'b0);
        checks++;
        if (out_a !== 1'b1) begin
            errs++; $display("FAIL async_restart: got %b want 1", out_a);
        end
        drain(8);
    endtask

    task automatic test_h1g1();
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b1);
            checks++;
            if (out_b !== (k % 2 == 0)) begin
                errs++; $display("FAIL h1g1_toggle k=%0d: got %b want %b", k, out_b, k % 2 == 0);
            end
            checks++;
            if (obs_b !== mexp(H2, G2, tb, sb, pb, ob)) begin
                errs++; $display("FAIL h1g1_model k=%0d: got %b want %b", k, obs_b, mexp(H2, G2, tb, sb, pb, ob));
            end
        end
        checks++;
        if (pend_b !== 2'd3) begin
            errs++; $display("FAIL h1g1_sat: got %0d want 3", pend_b);
        end
        drain(10);
    endtask

    task automatic test_random();
        logic va, vb;
        for (int k = 0; k < 400; k++) begin
            va = ($urandom_range(0, 99) < 35);
            vb = ($urandom_range(0, 99) < 30);
            step(va, vb);
            checks++;
            if (obs_a !== mexp(H, G, ta, sa, pa, oa)) begin
                errs++; $display("FAIL random_a k=%0d: got %b want %b", k, obs_a, mexp(H, G, ta, sa, pa, oa));
            end
            checks++;
            if (obs_b !== mexp(H2, G2, tb, sb, pb, ob)) begin
                errs++; $display("FAIL random_b k=%0d: got %b want %b", k, obs_b, mexp(H2, G2, tb, sb, pb, ob));
            end
        end
        drain(30);
        checks++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            errs++; $display("FAIL random_drain: got %b %b want 0 0", obs_a, obs_b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_gap_expiry();
        test_async_reset();
        test_h1g1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
